// File: rtl/cheshire_pad_tristate_if.sv
// SoC-side split signals of the Cheshire I2C / SPI-host pad adapter.
// The master is the SoC and the slave is the pad adapter.
interface cheshire_pad_tristate_if #(
  parameter int unsigned NumCs = 2
);
  logic             test_mode_i;
  logic             i2c_sda_o_i;
  logic             i2c_sda_en_i;
  logic             i2c_sda_i_o;
  logic             i2c_scl_o_i;
  logic             i2c_scl_en_i;
  logic             i2c_scl_i_o;
  logic             spih_sck_o_i;
  logic             spih_sck_en_i;
  logic [NumCs-1:0] spih_csb_o_i;
  logic [NumCs-1:0] spih_csb_en_i;
  logic [3:0]       spih_sd_o_i;
  logic [3:0]       spih_sd_en_i;
  logic [3:0]       spih_sd_i_o;
  logic             conflict_clr_i;
  logic [1:0]       i2c_conflict_o;

  modport master (
    output test_mode_i, i2c_sda_o_i, i2c_sda_en_i, i2c_scl_o_i, i2c_scl_en_i,
           spih_sck_o_i, spih_sck_en_i, spih_csb_o_i, spih_csb_en_i,
           spih_sd_o_i, spih_sd_en_i, conflict_clr_i,
    input  i2c_sda_i_o, i2c_scl_i_o, spih_sd_i_o, i2c_conflict_o
  );

  modport slave (
    input  test_mode_i, i2c_sda_o_i, i2c_sda_en_i, i2c_scl_o_i, i2c_scl_en_i,
           spih_sck_o_i, spih_sck_en_i, spih_csb_o_i, spih_csb_en_i,
           spih_sd_o_i, spih_sd_en_i, conflict_clr_i,
    output i2c_sda_i_o, i2c_scl_i_o, spih_sd_i_o, i2c_conflict_o
  );
endinterface

// File: rtl/cheshire_pad_tristate.sv
// Pad-level tristate adapter: bidirectional pad drive, board pulls in simulation,
// synchronised/deglitched I2C inputs and sticky I2C drive-contention flags.
module cheshire_pad_tristate #(
  parameter int unsigned NumCs      = 2,
  parameter int unsigned I2cFiltLen = 3,
  parameter int unsigned SpiSyncStg = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cheshire_pad_tristate_if.slave soc,
  inout  wire                    i2c_sda_io,
  inout  wire                    i2c_scl_io,
  inout  wire                    spih_sck_io,
  inout  wire  [NumCs-1:0]       spih_csb_io,
  inout  wire  [3:0]             spih_sd_io
);

  localparam int unsigned CntW = (I2cFiltLen < 2) ? 1 : $clog2(I2cFiltLen + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(I2cFiltLen - 1);

  // Pad drive: purely combinational, independent of clock and reset.
  assign i2c_sda_io  = soc.i2c_sda_en_i  ? soc.i2c_sda_o_i  : 1'bz;
  assign i2c_scl_io  = soc.i2c_scl_en_i  ? soc.i2c_scl_o_i  : 1'bz;
  assign spih_sck_io = soc.spih_sck_en_i ? soc.spih_sck_o_i : 1'bz;

  for (genvar i = 0; i < NumCs; i++) begin : g_csb
    assign spih_csb_io[i] = soc.spih_csb_en_i[i] ? soc.spih_csb_o_i[i] : 1'bz;
`ifndef SYNTHESIS
    pullup (spih_csb_io[i]);
`endif
  end

  for (genvar i = 0; i < 4; i++) begin : g_sd
    assign spih_sd_io[i] = soc.spih_sd_en_i[i] ? soc.spih_sd_o_i[i] : 1'bz;
`ifndef SYNTHESIS
    pulldown (spih_sd_io[i]);
`endif
  end

`ifndef SYNTHESIS
  pullup   (i2c_sda_io);
  pullup   (i2c_scl_io);
  pulldown (spih_sck_io);
`endif

  // I2C lines are handled as a pair: bit 0 = SDA, bit 1 = SCL.
  logic [1:0] pad_s;
  logic [1:0] pad_o;
  logic [1:0] pad_en;
  logic [1:0] sync_q1;
  logic [1:0] sync_q2;
  logic [1:0] filt_q;
  logic [CntW-1:0] filt_cnt [2];
  logic [1:0] en_d1;
  logic [1:0] en_d2;
  logic [1:0] o_d1;
  logic [1:0] o_d2;
  logic [1:0] conflict_q;

  // Anything other than a solid 0 (including x/z) reads as the pulled-up level.
  assign pad_s  = {(i2c_scl_io !== 1'b0), (i2c_sda_io !== 1'b0)};
  assign pad_o  = {soc.i2c_scl_o_i, soc.i2c_sda_o_i};
  assign pad_en = {soc.i2c_scl_en_i, soc.i2c_sda_en_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= pad_s;
      sync_q2 <= sync_q1;
    end
  end

  // Output flips only after I2cFiltLen consecutive samples disagree with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= '1;
      for (int unsigned i = 0; i < 2; i++) begin
        filt_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync_q2[i] == filt_q[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == CntMax) begin
          filt_q[i]   <= sync_q2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + CntW'(1);
        end
      end
    end
  end

  assign soc.i2c_sda_i_o = soc.test_mode_i ? sync_q2[0] : filt_q[0];
  assign soc.i2c_scl_i_o = soc.test_mode_i ? sync_q2[1] : filt_q[1];

  // Drive intent is delayed two cycles to line up with the synchronised pad.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_d1      <= '0;
      en_d2      <= '0;
      o_d1       <= '0;
      o_d2       <= '0;
      conflict_q <= '0;
    end else begin
      en_d1      <= pad_en;
      en_d2      <= en_d1;
      o_d1       <= pad_o;
      o_d2       <= o_d1;
      conflict_q <= (conflict_q & ~{2{soc.conflict_clr_i}}) | (en_d2 & o_d2 & ~sync_q2);
    end
  end

  assign soc.i2c_conflict_o = conflict_q;

  if (SpiSyncStg == 0) begin : g_sd_comb
    assign soc.spih_sd_i_o = spih_sd_io;
  end else begin : g_sd_sync
    logic [3:0] sd_q1;
    logic [3:0] sd_q2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sd_q1 <= '0;
        sd_q2 <= '0;
      end else begin
        sd_q1 <= spih_sd_io;
        sd_q2 <= sd_q1;
      end
    end

    assign soc.spih_sd_i_o = sd_q2;
  end

endmodule

// File: tb/tb_cheshire_pad_tristate.sv
// Self-checking bench for cheshire_pad_tristate (NumCs=2, I2cFiltLen=3, SpiSyncStg=0).
module tb_cheshire_pad_tristate;
  localparam int unsigned NumCs = 2;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb_q [$];

  wire             i2c_sda;
  wire             i2c_scl;
  wire             spih_sck;
  wire [NumCs-1:0] spih_csb;
  wire [3:0]       spih_sd;

  logic       ext_sda_en  = 1'b0;
  logic       ext_sda_val = 1'b1;
  logic       ext_scl_en  = 1'b0;
  logic       ext_scl_val = 1'b1;
  logic [3:0] ext_sd_en   = '0;
  logic [3:0] ext_sd_val  = '0;

  // External board devices; stronger than the pad driver so contention resolves to them.
  assign (supply0, supply1) i2c_sda = ext_sda_en ? ext_sda_val : 1'bz;
  assign (supply0, supply1) i2c_scl = ext_scl_en ? ext_scl_val : 1'bz;
  for (genvar g = 0; g < 4; g++) begin : g_ext_sd
    assign spih_sd[g] = ext_sd_en[g] ? ext_sd_val[g] : 1'bz;
  end

  cheshire_pad_tristate_if #(.NumCs(NumCs)) soc_if ();

  cheshire_pad_tristate #(
    .NumCs      (NumCs),
    .I2cFiltLen (3),
    .SpiSyncStg (0)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .soc         (soc_if),
    .i2c_sda_io  (i2c_sda),
    .i2c_scl_io  (i2c_scl),
    .spih_sck_io (spih_sck),
    .spih_csb_io (spih_csb),
    .spih_sd_io  (spih_sd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    soc_if.test_mode_i    = 1'b0;
    soc_if.i2c_sda_o_i    = 1'b0;
    soc_if.i2c_sda_en_i   = 1'b0;
    soc_if.i2c_scl_o_i    = 1'b0;
    soc_if.i2c_scl_en_i   = 1'b0;
    soc_if.spih_sck_o_i   = 1'b0;
    soc_if.spih_sck_en_i  = 1'b0;
    soc_if.spih_csb_o_i   = '0;
    soc_if.spih_csb_en_i  = '0;
    soc_if.spih_sd_o_i    = '0;
    soc_if.spih_sd_en_i   = '0;
    soc_if.conflict_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    init_inputs();
    rst_ni = 1'b0;
    #12;
    checks++;
    if ({i2c_sda, i2c_scl} !== 2'b11) begin
      errors++;
      $display("FAIL reset_i2c_pads: got %b expected 11", {i2c_sda, i2c_scl});
    end
    checks++;
    if ({spih_csb, spih_sck} !== 3'b110) begin
      errors++;
      $display("FAIL reset_csb_sck_pads: got %b expected 110", {spih_csb, spih_sck});
    end
    checks++;
    if (spih_sd !== 4'b0000) begin
      errors++;
      $display("FAIL reset_sd_pad: got %b expected 0000", spih_sd);
    end
    checks++;
    if ({soc_if.i2c_sda_i_o, soc_if.i2c_scl_i_o} !== 2'b11) begin
      errors++;
      $display("FAIL reset_i2c_in: got %b expected 11", {soc_if.i2c_sda_i_o, soc_if.i2c_scl_i_o});
    end
    checks++;
    if (soc_if.i2c_conflict_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_conflict: got %b expected 00", soc_if.i2c_conflict_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) step();
    checks++;
    if ({soc_if.i2c_sda_i_o, soc_if.i2c_scl_i_o, soc_if.i2c_conflict_o} !== 4'b1100) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 1100",
               {soc_if.i2c_sda_i_o, soc_if.i2c_scl_i_o, soc_if.i2c_conflict_o});
    end
  endtask

  task automatic test_sda_latency(input logic tm);
    int unsigned lat;
    logic [3:0] exp;
    lat = tm ? 2 : 5;
    soc_if.test_mode_i = tm;
    step();
    soc_if.i2c_sda_o_i  = 1'b0;
    soc_if.i2c_sda_en_i = 1'b1;
    for (int unsigned k = 1; k <= 8; k++) sb_q.push_back((k >= lat) ? 4'd0 : 4'd1);
    #1;
    checks++;
    if (i2c_sda !== 1'b0) begin
      errors++;
      $display("FAIL sda_pad_drive tm=%0d: got %b expected 0", tm, i2c_sda);
    end
    for (int unsigned k = 1; k <= 8; k++) begin
      step();
      exp = sb_q.pop_front();
      checks++;
      if (soc_if.i2c_sda_i_o !== exp[0]) begin
        errors++;
        $display("FAIL sda_latency tm=%0d cycle %0d: got %b expected %b",
                 tm, k, soc_if.i2c_sda_i_o, exp[0]);
      end
    end
    soc_if.i2c_sda_en_i = 1'b0;
    repeat (8) step();
    checks++;
    if (soc_if.i2c_sda_i_o !== 1'b1) begin
      errors++;
      $display("FAIL sda_recover tm=%0d: got %b expected 1", tm, soc_if.i2c_sda_i_o);
    end
    soc_if.test_mode_i = 1'b0;
  endtask

  task automatic test_scl_glitch(input int unsigned width);
    logic [3:0] exp;
    step();
    ext_scl_val = 1'b0;
    ext_scl_en  = 1'b1;
    for (int unsigned k = 1; k <= 12; k++)
      sb_q.push_back((width >= 3 && k >= 5 && k <= 4 + width) ? 4'd0 : 4'd1);
    for (int unsigned k = 1; k <= 12; k++) begin
      step();
      exp = sb_q.pop_front();
      checks++;
      if (soc_if.i2c_scl_i_o !== exp[0]) begin
        errors++;
        $display("FAIL scl_glitch w=%0d cycle %0d: got %b expected %b",
                 width, k, soc_if.i2c_scl_i_o, exp[0]);
      end
      if (k == width) ext_scl_en = 1'b0;
    end
  endtask

  task automatic test_conflict();
    logic [3:0] exp;
    step();
    soc_if.i2c_sda_o_i  = 1'b1;
    soc_if.i2c_sda_en_i = 1'b1;
    ext_sda_val = 1'b0;
    ext_sda_en  = 1'b1;
    for (int unsigned k = 1; k <= 11; k++)
      sb_q.push_back((k >= 3 && k <= 9) ? 4'b0001 : 4'b0000);
    for (int unsigned k = 1; k <= 11; k++) begin
      step();
      exp = sb_q.pop_front();
      checks++;
      if (soc_if.i2c_conflict_o !== exp[1:0]) begin
        errors++;
        $display("FAIL sda_conflict cycle %0d: got %b expected %b",
                 k, soc_if.i2c_conflict_o, exp[1:0]);
      end
      // First clear pulse overlaps an active set; the second comes once the line is free.
      if (k == 3 || k == 9) soc_if.conflict_clr_i = 1'b1;
      if (k == 4 || k == 10) soc_if.conflict_clr_i = 1'b0;
      if (k == 6) ext_sda_en = 1'b0;
    end
    soc_if.i2c_sda_en_i = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_spi_sd();
    logic [3:0] exp;
    logic [3:0] pats_en  [3] = '{4'b0000, 4'b0011, 4'b1111};
    logic [3:0] pats_o   [3] = '{4'h0,    4'hA,    4'h5};
    logic [3:0] pats_xen [3] = '{4'b0000, 4'b1100, 4'b0000};
    logic [3:0] pats_xv  [3] = '{4'b0000, 4'b0100, 4'b0000};
    logic [3:0] pats_exp [3] = '{4'b0000, 4'b0110, 4'b0101};
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      soc_if.spih_sd_en_i = pats_en[i];
      soc_if.spih_sd_o_i  = pats_o[i];
      ext_sd_en  = pats_xen[i];
      ext_sd_val = pats_xv[i];
      sb_q.push_back(pats_exp[i]);
      #1;
      exp = sb_q.pop_front();
      checks++;
      if (spih_sd !== exp) begin
        errors++;
        $display("FAIL sd_pad pat %0d: got %b expected %b", i, spih_sd, exp);
      end
      checks++;
      if (soc_if.spih_sd_i_o !== exp) begin
        errors++;
        $display("FAIL sd_in pat %0d: got %b expected %b", i, soc_if.spih_sd_i_o, exp);
      end
    end
    soc_if.spih_sd_en_i = '0;
    ext_sd_en = '0;
  endtask

  task automatic test_csb_sck();
    step();
    soc_if.spih_csb_en_i = 2'b11;
    soc_if.spih_csb_o_i  = 2'b10;
    soc_if.spih_sck_en_i = 1'b1;
    soc_if.spih_sck_o_i  = 1'b1;
    #1;
    checks++;
    if ({spih_csb, spih_sck} !== 3'b101) begin
      errors++;
      $display("FAIL csb_sck_driven: got %b expected 101", {spih_csb, spih_sck});
    end
    soc_if.spih_csb_en_i = 2'b00;
    soc_if.spih_sck_en_i = 1'b0;
    #1;
    checks++;
    if ({spih_csb, spih_sck} !== 3'b110) begin
      errors++;
      $display("FAIL csb_sck_released: got %b expected 110", {spih_csb, spih_sck});
    end
  endtask

  task automatic test_reset_mid();
    step();
    soc_if.i2c_sda_o_i  = 1'b0;
    soc_if.i2c_sda_en_i = 1'b1;
    soc_if.i2c_scl_o_i  = 1'b1;
    soc_if.i2c_scl_en_i = 1'b1;
    ext_scl_val = 1'b0;
    ext_scl_en  = 1'b1;
    repeat (7) step();
    checks++;
    if ({soc_if.i2c_sda_i_o, soc_if.i2c_conflict_o} !== 3'b010) begin
      errors++;
      $display("FAIL pre_reset_state: got %b expected 010",
               {soc_if.i2c_sda_i_o, soc_if.i2c_conflict_o});
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({soc_if.i2c_sda_i_o, soc_if.i2c_scl_i_o, soc_if.i2c_conflict_o} !== 4'b1100) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected 1100",
               {soc_if.i2c_sda_i_o, soc_if.i2c_scl_i_o, soc_if.i2c_conflict_o});
    end
    checks++;
    if (i2c_sda !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drive: got %b expected 0", i2c_sda);
    end
    ext_scl_en = 1'b0;
    init_inputs();
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sda_latency(1'b0);
    test_sda_latency(1'b1);
    test_scl_glitch(1);
    test_scl_glitch(3);
    test_conflict();
    test_spi_sd();
    test_csb_sck();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
